// File: rtl/lift_ctrl.sv
// lift_ctrl: six-floor lift sequencer.
//
// Tracks the outstanding calls and moves the cabin one floor at a time. It
// serves calls in the current direction first and holds the door open while
// the call button of the current floor is pressed.
//
// Ports
//   clk        system clock, all state on its rising edge
//   reset      synchronous, active-high reset
//   req[5:0]   call buttons, bit i = floor i (level, sampled every cycle)
//   E[2:0]     current floor 0..5
//   opcion     travel direction, 1 = up, 0 = down
//   enable_SB  high while the cabin is moving
//   enable_NUM high while the cabin is stopped
//   door_open  high while the door is open
//   pending    registered outstanding calls
module lift_ctrl #(
  parameter logic [31:0] FLOOR_TICKS = 32'd200_000_000,
  parameter logic [31:0] DOOR_TICKS  = 32'd300_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] req,
  output logic [2:0] E,
  output logic       opcion,
  output logic       enable_SB,
  output logic       enable_NUM,
  output logic       door_open,
  output logic [5:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  e_q, e_d;
  logic        opcion_q, opcion_d;
  logic [5:0]  pending_q, pending_d;
  logic        enable_sb_q, enable_sb_d;
  logic        enable_num_q, enable_num_d;
  logic        door_open_q, door_open_d;

  logic [5:0]  clr;        // pending bits retired this cycle
  logic [5:0]  e_onehot;   // current floor as a one-hot mask
  logic [5:0]  up_onehot;  // floor above the cabin
  logic [5:0]  dn_onehot;  // floor below the cabin
  logic        above, below, here;
  logic        floor_done, door_done;
  logic        door_hold;

  // Call summary relative to the cabin, always from registered pending so a
  // button press needs one full cycle before it can steer the sequencer.
  always_comb begin
    e_onehot   = 6'b000001 << e_q;
    up_onehot  = e_onehot << 1;
    dn_onehot  = e_onehot >> 1;
    above      = |(pending_q & (6'b111110 << e_q));
    below      = |(pending_q & ~(6'b111111 << e_q));
    here       = |(pending_q & e_onehot);
    floor_done = (cnt_q == FLOOR_TICKS - 32'd1);
    door_done  = (cnt_q == DOOR_TICKS - 32'd1);
    door_hold  = |(req & e_onehot);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    e_d      = e_q;
    opcion_d = opcion_q;
    clr      = 6'b000000;

    case (state_q)
      S_IDLE: begin
        // Counter parked at zero so every MOVE/DOOR entry starts fresh.
        cnt_d = 32'd0;
        if (here) begin
          state_d = S_DOOR;
          clr     = e_onehot;
        end else if (above && (opcion_q || !below)) begin
          state_d  = S_MOVE_UP;
          opcion_d = 1'b1;
        end else if (below) begin
          state_d  = S_MOVE_DOWN;
          opcion_d = 1'b0;
        end
      end

      S_MOVE_UP: begin
        if (e_q == 3'd5) begin
          // Nothing left to climb to; stop without touching the floor.
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end else if (floor_done) begin
          e_d   = e_q + 3'd1;
          cnt_d = 32'd0;
          if (|(pending_q & up_onehot)) begin
            state_d = S_DOOR;
            clr     = up_onehot;
          end
        end
      end

      S_MOVE_DOWN: begin
        if (e_q == 3'd0) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end else if (floor_done) begin
          e_d   = e_q - 3'd1;
          cnt_d = 32'd0;
          if (|(pending_q & dn_onehot)) begin
            state_d = S_DOOR;
            clr     = dn_onehot;
          end
        end
      end

      S_DOOR: begin
        // The cabin is already at this floor, so a press here is served
        // immediately and never becomes a pending call.
        clr = e_onehot;
        if (door_hold) begin
          cnt_d = 32'd0;
        end else if (door_done) begin
          cnt_d = 32'd0;
          if (opcion_q && above) begin
            state_d = S_MOVE_UP;
          end else if (!opcion_q && below) begin
            state_d = S_MOVE_DOWN;
          end else if (opcion_q && below) begin
            state_d  = S_MOVE_DOWN;
            opcion_d = 1'b0;
          end else if (!opcion_q && above) begin
            state_d  = S_MOVE_UP;
            opcion_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
      end
    endcase

    // A clear and a new press of the same floor resolve to cleared.
    pending_d = (pending_q | req) & ~clr;

    // Status outputs are registered copies of the next state.
    enable_sb_d  = (state_d == S_MOVE_UP) || (state_d == S_MOVE_DOWN);
    enable_num_d = !enable_sb_d;
    door_open_d  = (state_d == S_DOOR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      e_q          <= 3'd0;
      opcion_q     <= 1'b1;
      pending_q    <= 6'b000000;
      enable_sb_q  <= 1'b0;
      enable_num_q <= 1'b1;
      door_open_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      e_q          <= e_d;
      opcion_q     <= opcion_d;
      pending_q    <= pending_d;
      enable_sb_q  <= enable_sb_d;
      enable_num_q <= enable_num_d;
      door_open_q  <= door_open_d;
    end
  end

  assign E          = e_q;
  assign opcion     = opcion_q;
  assign enable_SB  = enable_sb_q;
  assign enable_NUM = enable_num_q;
  assign door_open  = door_open_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_lift_ctrl.sv
// Scoreboard bench for lift_ctrl with short floor/door timers.
module tb_lift_ctrl;
  localparam int FLOOR_T = 4;
  localparam int DOOR_T  = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] req = 6'b0;
  logic [2:0] E;
  logic       opcion, enable_SB, enable_NUM, door_open;
  logic [5:0] pending;

  lift_ctrl #(.FLOOR_TICKS(32'd4), .DOOR_TICKS(32'd6)) dut (
    .clk(clk), .reset(reset), .req(req), .E(E), .opcion(opcion),
    .enable_SB(enable_SB), .enable_NUM(enable_NUM), .door_open(door_open),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [12:0] t;   // {E, opcion, enable_SB, enable_NUM, door_open, pending}
  } ev_t;

  ev_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_on = 0;
  int          sb_seen = 0;
  int          door_seen = 0;
  logic [12:0] model_prev = '0;
  logic [12:0] dut_prev = '0;

  // Reference model: cabin position, direction, what it is doing, and a
  // countdown of cycles left in the current floor trip or door period.
  int       m_floor = 0;
  bit       m_up = 1;
  bit       m_moving = 0;
  bit       m_door = 0;
  bit [5:0] m_pend = '0;
  int       m_left = 0;

  function automatic void model_step(input bit rst, input logic [5:0] r);
    bit [5:0] old, clr;
    bit above, below;
    if (rst) begin
      m_floor = 0; m_up = 1; m_moving = 0; m_door = 0; m_pend = '0; m_left = 0;
      return;
    end
    old = m_pend; clr = '0; above = 0; below = 0;
    for (int f = 0; f < 6; f++) begin
      if (old[f] && f > m_floor) above = 1;
      if (old[f] && f < m_floor) below = 1;
    end
    if (m_door) begin
      clr[m_floor] = 1;
      if (r[m_floor]) m_left = DOOR_T;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_door = 0;
          if (m_up ? above : below) m_moving = 1;
          else if (m_up ? below : above) begin m_moving = 1; m_up = !m_up; end
          if (m_moving) m_left = FLOOR_T;
        end
      end
    end else if (m_moving) begin
      if ((m_up && m_floor == 5) || (!m_up && m_floor == 0)) m_moving = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_up ? 1 : -1;
          if (old[m_floor]) begin
            m_moving = 0; m_door = 1; m_left = DOOR_T; clr[m_floor] = 1;
          end else m_left = FLOOR_T;
        end
      end
    end else begin
      if (old[m_floor]) begin
        m_door = 1; m_left = DOOR_T; clr[m_floor] = 1;
      end else if (above && (m_up || !below)) begin
        m_moving = 1; m_up = 1; m_left = FLOOR_T;
      end else if (below) begin
        m_moving = 1; m_up = 0; m_left = FLOOR_T;
      end
    end
    m_pend = (old | r) & ~clr;
  endfunction

  function automatic logic [12:0] model_tuple();
    return {3'(m_floor), m_up, m_moving, !m_moving, m_door, m_pend};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; the model advances on the same edge and any change in
  // its outputs is queued as the next expected DUT output event.
  task automatic tick(input logic rst_v, input logic [5:0] r);
    logic [12:0] mt;
    ev_t ev;
    reset = rst_v; req = r;
    @(posedge clk);
    cyc++;
    model_step(rst_v, r);
    mt = model_tuple();
    if (mon_on && mt != model_prev) begin
      ev.cyc = cyc; ev.t = mt;
      sb_q.push_back(ev);
    end
    model_prev = mt;
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 6'b0);
  endtask

  // Monitor: every change of the DUT outputs pops one expected event.
  initial begin
    logic [12:0] cur;
    ev_t ev;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cur = {E, opcion, enable_SB, enable_NUM, door_open, pending};
        checks++;
        if ((enable_SB ^ enable_NUM) !== 1'b1 || (door_open && !enable_NUM)) begin
          errors++;
          $display("FAIL invariant cyc=%0d: got sb=%b num=%b door=%b", cyc, enable_SB, enable_NUM, door_open);
        end
        if (enable_SB) sb_seen++;
        if (door_open) door_seen++;
        if (cur !== dut_prev) begin
          dut_prev = cur;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d: got %h expected no change", cyc, cur);
          end else begin
            ev = sb_q.pop_front();
            if (ev.t !== cur || ev.cyc != cyc) begin
              errors++;
              $display("FAIL output_event: got %h at cyc %0d expected %h at cyc %0d", cur, cyc, ev.t, ev.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    int hold;
    int dcount;
    logic [5:0] r;

    tick(1'b1, 6'b111111);
    tick(1'b1, 6'b000000);
    chk("reset_E", 32'(E), 0);
    chk("reset_opcion", 32'(opcion), 1);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_enable_SB", 32'(enable_SB), 0);
    chk("reset_enable_NUM", 32'(enable_NUM), 1);
    chk("reset_door_open", 32'(door_open), 0);
    dut_prev = {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0};
    sb_q.delete();
    mon_on = 1;

    // Call at the current floor: door opens with no movement.
    sb_seen = 0; door_seen = 0;
    tick(1'b0, 6'b000001);
    run(12);
    chk("same_floor_no_move", 32'(sb_seen), 0);
    chk("same_floor_door", 32'(door_seen != 0), 1);

    // Single call to floor 3, then opposite-end calls from floor 3.
    tick(1'b0, 6'b001000);
    run(30);
    chk("at_floor3", 32'(E), 3);
    tick(1'b0, 6'b100001);
    run(60);
    chk("back_at_floor0", 32'(E), 0);

    // Call at floor 2 inserted while already heading up to floor 4.
    tick(1'b0, 6'b010000);
    hold = 0;
    while (!(m_moving && m_floor == 1) && hold < 40) begin run(1); hold++; end
    chk("reach_floor1_bound", 32'(hold < 40), 1);
    tick(1'b0, 6'b000100);
    run(40);
    chk("at_floor4", 32'(E), 4);

    // Door held by the floor-2 button for 3 cycles.
    tick(1'b0, 6'b000100);
    hold = 0;
    while (!(m_door && m_floor == 2) && hold < 60) begin run(1); hold++; end
    chk("door_at_2_bound", 32'(hold < 60), 1);
    for (int k = 0; k < 3; k++) tick(1'b0, 6'b000100);
    dcount = door_open ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 6'b0);
      if (door_open) dcount++;
    end
    chk("door_hold_len", 32'(dcount), DOOR_T);

    // Reset while passing floor 2 going up, with buttons pressed.
    tick(1'b0, 6'b000001);
    run(40);
    tick(1'b0, 6'b100000);
    hold = 0;
    while (!(m_moving && m_up && m_floor == 2) && hold < 60) begin run(1); hold++; end
    chk("move_at_2_bound", 32'(hold < 60), 1);
    tick(1'b1, 6'b111111);
    chk("midmove_reset_E", 32'(E), 0);
    chk("midmove_reset_pending", 32'(pending), 0);
    chk("midmove_reset_num", 32'(enable_NUM), 1);
    chk("midmove_reset_sb", 32'(enable_SB), 0);
    chk("midmove_reset_opcion", 32'(opcion), 1);

    // Random traffic with occasional held buttons and resets.
    hold = 0; r = '0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          r = 6'($urandom_range(1, 63));
          hold = $urandom_range(1, 3);
        end else r = '0;
      end
      if (hold > 0) hold--;
      tick($urandom_range(0, 299) == 0, r);
    end
    run(120);
    chk("scoreboard_drain", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
